ram2_ctrl: RTL and testbench

RAM2_CTRL -- requirements
Module: ram2_ctrl

---
 rtl/ram2_pkg.sv | 28 ++
 rtl/ram2_arb.sv | 23 ++
 rtl/ram2_ctrl.sv | 127 ++++++++++++
 tb/tb_ram2_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram2_pkg.sv
// Shared definitions for the RAM2 SRAM controller: FSM state encoding,
// grant encoding and SRAM access timing constants.
package ram2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR1  = 3'd2,
        ST_WR2  = 3'd3,
        ST_WR3  = 3'd4,
        ST_DONE = 3'd5
    } ram2_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_F    = 2'd1,
        GNT_D    = 2'd2
    } ram2_gnt_e;

    // Cycles from the accepting edge to the cycle carrying the done pulse.
    localparam int unsigned RD_LATENCY = 32'd2;
    localparam int unsigned WR_LATENCY = 32'd4;

    function automatic logic [17:0] ram2_addr_ext(input logic [15:0] word_addr);
        return {2'b00, word_addr};
    endfunction

endpackage

// File: rtl/ram2_arb.sv
// Fixed-priority arbiter between the data port and the fetch port;
// the data port always wins a simultaneous request.
module ram2_arb
    import ram2_pkg::*;
(
    input  logic      f_req,
    input  logic      d_req,
    output ram2_gnt_e gnt
);

    // Pick the winning port for the current IDLE cycle.
    always_comb begin
        gnt = GNT_NONE;
        if (d_req) begin
            gnt = GNT_D;
        end else if (f_req) begin
            gnt = GNT_F;
        end else begin
            gnt = GNT_NONE;
        end
    end

endmodule

// File: rtl/ram2_ctrl.sv
// Asynchronous SRAM controller serving a fetch port and a data port with
// a six-state access FSM; all SRAM strobes and done pulses are registered.
module ram2_ctrl
    import ram2_pkg::*;
(
    input  logic        rci_clk,
    input  logic        rci_rst,
    input  logic        rci_f_req,
    input  logic [15:0] rci_f_addr,
    input  logic        rci_d_req,
    input  logic        rci_d_we,
    input  logic [15:0] rci_d_addr,
    input  logic [15:0] rci_d_wdata,
    output logic        rco_f_done,
    output logic        rco_d_done,
    output logic [15:0] rco_rdata,
    output logic [17:0] rco_ram2_addr,
    inout  wire  [15:0] rcio_ram2_data,
    output logic        rco_ram2_en_n,
    output logic        rco_ram2_oe_n,
    output logic        rco_ram2_we_n
);

    ram2_state_e state_r;
    ram2_gnt_e   gnt_s;
    logic        gnt_d_r;
    logic [17:0] ram2_addr_r;
    logic [15:0] wdata_r;
    logic        drive_r;
    logic        en_n_r;
    logic        oe_n_r;
    logic        we_n_r;
    logic [15:0] rdata_r;
    logic        f_done_r;
    logic        d_done_r;

    ram2_arb u_arb (
        .f_req (rci_f_req),
        .d_req (rci_d_req),
        .gnt   (gnt_s)
    );

    // Access FSM; strobes are set on the edge entering each state so they are glitch-free.
    always_ff @(posedge rci_clk or negedge rci_rst) begin
        if (!rci_rst) begin
            state_r     <= ST_IDLE;
            gnt_d_r     <= 1'b0;
            ram2_addr_r <= 18'h0_0000;
            wdata_r     <= 16'h0000;
            drive_r     <= 1'b0;
            en_n_r      <= 1'b1;
            oe_n_r      <= 1'b1;
            we_n_r      <= 1'b1;
            rdata_r     <= 16'h0000;
            f_done_r    <= 1'b0;
            d_done_r    <= 1'b0;
        end else begin
            f_done_r <= 1'b0;
            d_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (gnt_s != GNT_NONE) begin
                        gnt_d_r     <= (gnt_s == GNT_D);
                        en_n_r      <= 1'b0;
                        ram2_addr_r <= ram2_addr_ext((gnt_s == GNT_D) ? rci_d_addr : rci_f_addr);
                        wdata_r     <= rci_d_wdata;
                        if ((gnt_s == GNT_D) && rci_d_we) begin
                            state_r <= ST_WR1;
                            drive_r <= 1'b1;
                        end else begin
                            state_r <= ST_RD;
                            oe_n_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    rdata_r     <= rcio_ram2_data;
                    en_n_r      <= 1'b1;
                    oe_n_r      <= 1'b1;
                    ram2_addr_r <= 18'h0_0000;
                    f_done_r    <= ~gnt_d_r;
                    d_done_r    <= gnt_d_r;
                    state_r     <= ST_DONE;
                end
                ST_WR1: begin
                    we_n_r  <= 1'b0;
                    state_r <= ST_WR2;
                end
                ST_WR2: begin
                    we_n_r  <= 1'b1;
                    state_r <= ST_WR3;
                end
                ST_WR3: begin
                    en_n_r      <= 1'b1;
                    drive_r     <= 1'b0;
                    ram2_addr_r <= 18'h0_0000;
                    f_done_r    <= ~gnt_d_r;
                    d_done_r    <= gnt_d_r;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    drive_r     <= 1'b0;
                    en_n_r      <= 1'b1;
                    oe_n_r      <= 1'b1;
                    we_n_r      <= 1'b1;
                    ram2_addr_r <= 18'h0_0000;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rcio_ram2_data = drive_r ? wdata_r : 16'hzzzz;
    assign rco_ram2_addr  = ram2_addr_r;
    assign rco_ram2_en_n  = en_n_r;
    assign rco_ram2_oe_n  = oe_n_r;
    assign rco_ram2_we_n  = we_n_r;
    assign rco_rdata      = rdata_r;
    assign rco_f_done     = f_done_r;
    assign rco_d_done     = d_done_r;

endmodule

// File: tb/tb_ram2_ctrl.sv
// Bench for ram2_ctrl: SRAM model on the bus, transaction-level reference
// model with per-cycle compare, directed scenarios and random traffic.
module tb_ram2_ctrl;
    import ram2_pkg::*;

    logic        rci_clk;
    logic        rci_rst;
    logic        rci_f_req;
    logic [15:0] rci_f_addr;
    logic        rci_d_req;
    logic        rci_d_we;
    logic [15:0] rci_d_addr;
    logic [15:0] rci_d_wdata;
    logic        rco_f_done;
    logic        rco_d_done;
    logic [15:0] rco_rdata;
    logic [17:0] rco_ram2_addr;
    wire  [15:0] rcio_ram2_data;
    logic        rco_ram2_en_n;
    logic        rco_ram2_oe_n;
    logic        rco_ram2_we_n;

    logic [15:0] sram    [0:65535];
    logic [15:0] ref_mem [0:65535];

    int n_pass = 0;
    int n_total = 0;
    int dut_fdone_cnt = 0;
    int exp_fdone_cnt = 0;

    ram2_ctrl dut (
        .rci_clk        (rci_clk),
        .rci_rst        (rci_rst),
        .rci_f_req      (rci_f_req),
        .rci_f_addr     (rci_f_addr),
        .rci_d_req      (rci_d_req),
        .rci_d_we       (rci_d_we),
        .rci_d_addr     (rci_d_addr),
        .rci_d_wdata    (rci_d_wdata),
        .rco_f_done     (rco_f_done),
        .rco_d_done     (rco_d_done),
        .rco_rdata      (rco_rdata),
        .rco_ram2_addr  (rco_ram2_addr),
        .rcio_ram2_data (rcio_ram2_data),
        .rco_ram2_en_n  (rco_ram2_en_n),
        .rco_ram2_oe_n  (rco_ram2_oe_n),
        .rco_ram2_we_n  (rco_ram2_we_n)
    );

    initial rci_clk = 1'b0;
    always #5 rci_clk = ~rci_clk;

    // Asynchronous SRAM: drives on read strobes, stores the bus while en_n and we_n are low.
    assign rcio_ram2_data = (!rco_ram2_en_n && !rco_ram2_oe_n && rco_ram2_we_n)
                            ? sram[rco_ram2_addr[15:0]] : 16'hzzzz;
    always @(posedge rci_clk) begin
        if (rci_rst && !rco_ram2_en_n && !rco_ram2_we_n)
            sram[rco_ram2_addr[15:0]] <= rcio_ram2_data;
    end

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Reference model: each accepted access expands into a list of expected bus cycles.
    typedef struct {
        bit          busy;
        bit          is_done;
        bit          chk_addr;
        bit          is_wr;
        bit          drive;
        logic        en_n, oe_n, we_n, f_done, d_done;
        logic [17:0] addr;
        logic [15:0] a, wdata, rd_val;
    } cyc_t;

    cyc_t q[$];
    cyc_t cur;
    logic [15:0] exp_rdata = 16'h0000;

    function automatic cyc_t mk(input bit busy, input logic en_n, input logic oe_n, input logic we_n,
                                input logic [15:0] a, input bit drive, input logic [15:0] wd);
        cyc_t c;
        c.busy = busy; c.is_done = 1'b0; c.chk_addr = 1'b1; c.is_wr = 1'b0; c.drive = drive;
        c.en_n = en_n; c.oe_n = oe_n; c.we_n = we_n; c.f_done = 1'b0; c.d_done = 1'b0;
        c.addr = busy ? {2'b00, a} : 18'h0_0000; c.a = a; c.wdata = wd; c.rd_val = 16'h0000;
        return c;
    endfunction

    function automatic cyc_t mk_done(input bit is_d, input bit is_wr, input logic [15:0] a,
                                     input logic [15:0] wd, input logic [15:0] rv);
        cyc_t c;
        c = mk(1'b1, 1'b1, 1'b1, 1'b1, a, 1'b0, wd);
        c.is_done = 1'b1; c.chk_addr = 1'b0; c.is_wr = is_wr; c.rd_val = rv;
        c.f_done = !is_d; c.d_done = is_d;
        return c;
    endfunction

    initial cur = mk(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000);

    always @(posedge rci_clk) begin
        if (!rci_rst) begin
            q.delete();
            cur = mk(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000);
            exp_rdata = 16'h0000;
        end else begin
            if (q.size() == 0 && !cur.busy) begin
                if (rci_d_req && rci_d_we) begin
                    q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, rci_d_addr, 1'b1, rci_d_wdata));
                    q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, rci_d_addr, 1'b1, rci_d_wdata));
                    q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, rci_d_addr, 1'b1, rci_d_wdata));
                    q.push_back(mk_done(1'b1, 1'b1, rci_d_addr, rci_d_wdata, 16'h0000));
                end else if (rci_d_req) begin
                    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, rci_d_addr, 1'b0, 16'h0000));
                    q.push_back(mk_done(1'b1, 1'b0, rci_d_addr, 16'h0000, ref_mem[rci_d_addr]));
                end else if (rci_f_req) begin
                    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, rci_f_addr, 1'b0, 16'h0000));
                    q.push_back(mk_done(1'b0, 1'b0, rci_f_addr, 16'h0000, ref_mem[rci_f_addr]));
                end
            end
            if (q.size() > 0) cur = q.pop_front();
            else cur = mk(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000);
            if (cur.is_done) begin
                if (cur.is_wr) ref_mem[cur.a] = cur.wdata;
                else exp_rdata = cur.rd_val;
                if (cur.f_done) exp_fdone_cnt++;
            end
            #1;
            if (rco_f_done) dut_fdone_cnt++;
            check_eq("cyc_ctl", {27'd0, rco_f_done, rco_d_done, rco_ram2_en_n, rco_ram2_oe_n, rco_ram2_we_n},
                     {27'd0, cur.f_done, cur.d_done, cur.en_n, cur.oe_n, cur.we_n});
            if (cur.chk_addr) check_eq("cyc_addr", {14'd0, rco_ram2_addr}, {14'd0, cur.addr});
            check_eq("cyc_rdata", {16'd0, rco_rdata}, {16'd0, exp_rdata});
            if (cur.drive) check_eq("cyc_bus", {16'd0, rcio_ram2_data}, {16'd0, cur.wdata});
        end
    end

    // One data or fetch access; reports cycles to done, we_n-low cycles, and wrong-port dones.
    task automatic access(input bit use_d, input logic we, input logic [15:0] a, input logic [15:0] wd,
                          output int lat, output int wel, output int other);
        lat = 0; wel = 0; other = 0;
        @(negedge rci_clk);
        if (use_d) begin
            rci_d_req = 1'b1; rci_d_we = we; rci_d_addr = a; rci_d_wdata = wd;
        end else begin
            rci_f_req = 1'b1; rci_f_addr = a;
        end
        @(posedge rci_clk);
        for (int i = 1; i <= int'(WR_LATENCY) + 6; i++) begin
            #1;
            if (!rco_ram2_we_n) wel++;
            if (use_d ? rco_f_done : rco_d_done) other++;
            if (use_d ? rco_d_done : rco_f_done) begin
                lat = i;
                break;
            end
            @(posedge rci_clk);
        end
        @(negedge rci_clk);
        rci_d_req = 1'b0; rci_f_req = 1'b0;
        repeat (2) @(negedge rci_clk);
    endtask

    function automatic logic [15:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 7));
        case (r)
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2, 3:    return 16'($urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int lat, wel, other, d_at, f_at, base, cnt, nf, nrd;
        int f_at_v [0:1];
        logic [17:0] rd_addr [0:1];
        logic prev_f;

        for (int i = 0; i < 65536; i++) begin
            sram[i] = 16'(i) ^ 16'h5A5A;
            ref_mem[i] = 16'(i) ^ 16'h5A5A;
        end
        sram[16'h0010] = 16'h4A21; ref_mem[16'h0010] = 16'h4A21;
        sram[16'h0005] = 16'hA5A5; ref_mem[16'h0005] = 16'hA5A5;

        rci_rst = 1'b1; rci_f_req = 1'b0; rci_d_req = 1'b0; rci_d_we = 1'b0;
        rci_f_addr = 16'h0000; rci_d_addr = 16'h0000; rci_d_wdata = 16'h0000;
        #2 rci_rst = 1'b0;
        #1;
        check_eq("reset_strobes", {29'd0, rco_ram2_en_n, rco_ram2_oe_n, rco_ram2_we_n}, 32'h7);
        check_eq("reset_done", {30'd0, rco_f_done, rco_d_done}, 32'h0);
        check_eq("reset_rdata", {16'd0, rco_rdata}, 32'h0);
        repeat (3) @(negedge rci_clk);
        rci_rst = 1'b1;
        repeat (2) @(negedge rci_clk);

        // Fetch only.
        access(1'b0, 1'b0, 16'h0010, 16'h0000, lat, wel, other);
        check_eq("fetch_latency", lat, 32'd2);
        check_eq("fetch_rdata", {16'd0, rco_rdata}, 32'h4A21);
        check_eq("fetch_no_d_done", other, 32'd0);

        // Write then read back.
        access(1'b1, 1'b1, 16'h8000, 16'hBEEF, lat, wel, other);
        check_eq("write_latency", lat, 32'd4);
        check_eq("write_we_low_cycles", wel, 32'd1);
        check_eq("write_rdata_held", {16'd0, rco_rdata}, 32'h4A21);
        access(1'b1, 1'b0, 16'h8000, 16'h0000, lat, wel, other);
        check_eq("readback_latency", lat, 32'd2);
        check_eq("readback_rdata", {16'd0, rco_rdata}, 32'hBEEF);

        // Simultaneous requests: data first, fetch after one IDLE cycle.
        base = dut_fdone_cnt; d_at = 0; f_at = 0;
        @(negedge rci_clk);
        rci_d_req = 1'b1; rci_d_we = 1'b0; rci_d_addr = 16'h0200; rci_f_req = 1'b1; rci_f_addr = 16'h0011;
        @(posedge rci_clk);
        for (int i = 1; i <= 14; i++) begin
            #1;
            if (rco_d_done) d_at = i;
            if (rco_f_done) f_at = i;
            if (i == 3) base = dut_fdone_cnt - base;
            @(negedge rci_clk);
            if (d_at != 0) rci_d_req = 1'b0;
            if (f_at != 0) begin
                rci_f_req = 1'b0;
                break;
            end
            @(posedge rci_clk);
        end
        check_eq("simul_d_done_cycle", d_at, 32'd2);
        check_eq("simul_f_done_cycle", f_at, 32'd5);
        check_eq("simul_pc_no_adv_on_d", base, 32'd0);
        check_eq("simul_rdata", {16'd0, rco_rdata}, 32'h0011 ^ 32'h5A5A);
        repeat (2) @(negedge rci_clk);

        // Back-to-back fetches at the address extremes.
        nf = 0; nrd = 0; cnt = 0; prev_f = 1'b0;
        f_at_v[0] = 0; f_at_v[1] = 0; rd_addr[0] = 18'h3FFFF; rd_addr[1] = 18'h3FFFF;
        @(negedge rci_clk);
        rci_f_req = 1'b1; rci_f_addr = 16'hFFFF;
        @(posedge rci_clk);
        for (int i = 1; i <= 14; i++) begin
            #1;
            if (!rco_ram2_oe_n && nrd < 2) begin rd_addr[nrd] = rco_ram2_addr; nrd++; end
            if (rco_f_done && prev_f) cnt++;
            prev_f = rco_f_done;
            if (rco_f_done && nf < 2) begin f_at_v[nf] = i; nf++; end
            @(negedge rci_clk);
            if (rco_f_done && nf == 1) rci_f_addr = 16'h0000;
            if (nf == 2) begin
                rci_f_req = 1'b0;
                break;
            end
            @(posedge rci_clk);
        end
        check_eq("b2b_addr_first", {14'd0, rd_addr[0]}, 32'h0FFFF);
        check_eq("b2b_addr_second", {14'd0, rd_addr[1]}, 32'h00000);
        check_eq("b2b_done_first", f_at_v[0], 32'd2);
        check_eq("b2b_done_second", f_at_v[1], 32'd5);
        check_eq("b2b_done_single_cycle", cnt, 32'd0);
        repeat (2) @(negedge rci_clk);

        // Reset during WR2 aborts the write.
        @(negedge rci_clk);
        rci_d_req = 1'b1; rci_d_we = 1'b1; rci_d_addr = 16'h0005; rci_d_wdata = 16'h1234;
        @(posedge rci_clk);
        @(posedge rci_clk);
        #1;
        check_eq("wr2_we_low", {31'd0, rco_ram2_we_n}, 32'd0);
        @(negedge rci_clk);
        rci_rst = 1'b0; rci_d_req = 1'b0;
        #1;
        check_eq("rst_wr2_strobes", {29'd0, rco_ram2_en_n, rco_ram2_oe_n, rco_ram2_we_n}, 32'h7);
        check_eq("rst_wr2_done", {30'd0, rco_f_done, rco_d_done}, 32'h0);
        check_eq("rst_wr2_rdata", {16'd0, rco_rdata}, 32'h0);
        repeat (2) @(negedge rci_clk);
        rci_rst = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(posedge rci_clk);
            #1;
            if (rco_d_done || rco_f_done) cnt++;
        end
        check_eq("rst_wr2_no_done_after", cnt, 32'd0);
        check_eq("rst_wr2_sram_unchanged", {16'd0, sram[16'h0005]}, 32'hA5A5);

        // Random traffic on both ports against the reference model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge rci_clk);
            if (rci_d_req) begin
                if (rco_d_done) rci_d_req = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                rci_d_req = 1'b1;
                rci_d_we = 1'($urandom_range(0, 1));
                rci_d_addr = pick_addr();
                rci_d_wdata = 16'($urandom);
            end
            if (rci_f_req) begin
                if (rco_f_done) rci_f_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                rci_f_req = 1'b1;
                rci_f_addr = pick_addr();
            end
        end
        @(negedge rci_clk);
        rci_d_req = 1'b0; rci_f_req = 1'b0;
        repeat (12) @(negedge rci_clk);
        check_eq("pc_advance_count", dut_fdone_cnt, exp_fdone_cnt);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
